// File: rtl/mvd_bits_acc_if.sv
// Bus bundle for mvd_bits_acc: the MVD beat stream in, the packet bit total out.
// master = producer of beats / consumer of totals, slave = the accumulator.
interface mvd_bits_acc_if #(
    parameter int MVD_WIDTH = 12,
    parameter int NUM_CH    = 4,
    parameter int SUM_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [NUM_CH-1:0]           in_mask;
    logic [NUM_CH*MVD_WIDTH-1:0] in_mvd;
    logic                        out_valid;
    logic                        out_ready;
    logic [SUM_WIDTH-1:0]        out_bits;
    logic                        out_sat;

    modport master (
        output in_valid, in_last, in_mask, in_mvd, out_ready,
        input  in_ready, out_valid, out_bits, out_sat
    );

    modport slave (
        input  in_valid, in_last, in_mask, in_mvd, out_ready,
        output in_ready, out_valid, out_bits, out_sat
    );
endinterface

// File: rtl/mvd_bits_acc.sv
// Exp-Golomb bit-cost estimator for MVD beats: per-channel code length in S1,
// saturating packet accumulation in S2, total handed out over valid/ready.
module mvd_bits_acc #(
    parameter int MVD_WIDTH = 12,
    parameter int NUM_CH    = 4,
    parameter int K         = 0,
    parameter int SUM_WIDTH = 16
) (
    input logic          clk,
    input logic          rstn,
    mvd_bits_acc_if.slave bus
);
    // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
    // A source holds valid and its payload until that edge; ready never depends on valid.

    localparam int CW = MVD_WIDTH + 1;
    localparam int LW = 7;
    localparam int BW = LW + $clog2(NUM_CH);
    localparam int TW = ((SUM_WIDTH > BW) ? SUM_WIDTH : BW) + 1;
    localparam logic [SUM_WIDTH-1:0] SUM_MAX = '1;

    // Signed-to-unsigned Exp-Golomb mapping; the most negative input lands on 2^MVD_WIDTH.
    function automatic logic [CW-1:0] code_num(input logic [MVD_WIDTH-1:0] v);
        logic [CW-1:0] vx;
        vx = {v[MVD_WIDTH-1], v};
        if (!v[MVD_WIDTH-1] && (v != '0))
            return (vx << 1) - CW'(1);
        else
            return CW'(0) - (vx << 1);
    endfunction

    function automatic logic [LW-1:0] code_len(input logic [CW-1:0] code);
        logic [CW:0]    x;
        logic [LW-1:0]  msb;
        x   = {1'b0, code >> K} + (CW+1)'(1);
        msb = '0;
        for (int i = 0; i <= CW; i++) begin
            if (x[i]) msb = LW'(i);
        end
        return {msb[LW-2:0], 1'b0} + LW'(1) + LW'(K);
    endfunction

    logic                      adv;
    logic [NUM_CH-1:0][LW-1:0] in_len;
    logic                      s1_valid;
    logic                      s1_last;
    logic [NUM_CH-1:0][LW-1:0] s1_len;
    logic [BW-1:0]             beat_sum;
    logic [TW-1:0]             raw_total;
    logic [SUM_WIDTH-1:0]      total;
    logic                      clip;
    logic [SUM_WIDTH-1:0]      acc;
    logic                      sat_flag;
    logic                      out_valid_q;
    logic [SUM_WIDTH-1:0]      out_bits_q;
    logic                      out_sat_q;

    // The whole pipeline moves only when the output slot is free or being emptied.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin
        in_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.in_mask[i])
                in_len[i] = code_len(code_num(bus.in_mvd[i*MVD_WIDTH +: MVD_WIDTH]));
        end
    end

    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            beat_sum = beat_sum + BW'(s1_len[i]);
        end
    end

    always_comb begin
        raw_total = TW'(acc) + TW'(beat_sum);
        clip      = 1'b0;
        total     = raw_total[SUM_WIDTH-1:0];
        if (raw_total > TW'(SUM_MAX)) begin
            clip  = 1'b1;
            total = SUM_MAX;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_len   <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_last  <= bus.in_last;
            s1_len   <= in_len;
        end
    end

    // A last beat reaching S2 refills the output slot on the same edge it is drained.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc         <= '0;
            sat_flag    <= 1'b0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            out_valid_q <= 1'b0;
            if (s1_valid) begin
                if (s1_last) begin
                    out_bits_q  <= total;
                    out_sat_q   <= sat_flag | clip;
                    out_valid_q <= 1'b1;
                    acc         <= '0;
                    sat_flag    <= 1'b0;
                end else begin
                    acc      <= total;
                    sat_flag <= sat_flag | clip;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_bits  = out_bits_q;
    assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_mvd_bits_acc.sv
// Directed bench for mvd_bits_acc: three instances (K=0/16b, K=1/16b, K=0/6b)
// share one beat stream; totals are checked directly and through a scoreboard.
module tb_mvd_bits_acc;
    logic clk;
    logic rstn;

    logic        drv_valid;
    logic        drv_last;
    logic [3:0]  drv_mask;
    logic [47:0] drv_mvd;
    logic        drv_out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    mvd_bits_acc_if #(.MVD_WIDTH(12), .NUM_CH(4), .SUM_WIDTH(16)) if_def ();
    mvd_bits_acc_if #(.MVD_WIDTH(12), .NUM_CH(4), .SUM_WIDTH(16)) if_k1 ();
    mvd_bits_acc_if #(.MVD_WIDTH(12), .NUM_CH(4), .SUM_WIDTH(6))  if_s6 ();

    assign if_def.in_valid  = drv_valid;
    assign if_def.in_last   = drv_last;
    assign if_def.in_mask   = drv_mask;
    assign if_def.in_mvd    = drv_mvd;
    assign if_def.out_ready = drv_out_ready;
    assign if_k1.in_valid   = drv_valid;
    assign if_k1.in_last    = drv_last;
    assign if_k1.in_mask    = drv_mask;
    assign if_k1.in_mvd     = drv_mvd;
    assign if_k1.out_ready  = drv_out_ready;
    assign if_s6.in_valid   = drv_valid;
    assign if_s6.in_last    = drv_last;
    assign if_s6.in_mask    = drv_mask;
    assign if_s6.in_mvd     = drv_mvd;
    assign if_s6.out_ready  = drv_out_ready;

    mvd_bits_acc #(.MVD_WIDTH(12), .NUM_CH(4), .K(0), .SUM_WIDTH(16)) u_def (
        .clk(clk), .rstn(rstn), .bus(if_def)
    );
    mvd_bits_acc #(.MVD_WIDTH(12), .NUM_CH(4), .K(1), .SUM_WIDTH(16)) u_k1 (
        .clk(clk), .rstn(rstn), .bus(if_k1)
    );
    mvd_bits_acc #(.MVD_WIDTH(12), .NUM_CH(4), .K(0), .SUM_WIDTH(6)) u_s6 (
        .clk(clk), .rstn(rstn), .bus(if_s6)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_beat(input logic [47:0] mvd, input logic [3:0] mask, input logic last);
        int n;
        n = 0;
        drv_mvd   = mvd;
        drv_mask  = mask;
        drv_last  = last;
        drv_valid = 1'b1;
        while (!if_def.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(n < 50), 32'd1);
        @(negedge clk);
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    // scoreboard on the default instance: every output handshake pops one expected total
    always @(posedge clk) begin
        if (rstn && if_def.out_valid && if_def.out_ready) begin
            if (exp_q.size() == 0)
                check("sb_unexpected", 32'd1, 32'd0);
            else
                check("sb_bits", 32'(if_def.out_bits), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rstn          = 1'b0;
        drv_valid     = 1'b0;
        drv_last      = 1'b0;
        drv_mask      = '0;
        drv_mvd       = '0;
        drv_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(if_def.in_ready),  32'd1);
        check("rst_out_valid", 32'(if_def.out_valid), 32'd0);
        check("rst_out_bits",  32'(if_def.out_bits),  32'd0);
        check("rst_out_sat",   32'(if_def.out_sat),   32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // single-beat packet: 5+3+3+1
        exp_q.push_back(16'd12);
        send_beat(pack4(3, -1, 1, 0), 4'b1111, 1'b1);
        check("t1_not_yet", 32'(if_def.out_valid), 32'd0);
        @(negedge clk);
        check("t1_valid", 32'(if_def.out_valid), 32'd1);
        check("t1_bits",  32'(if_def.out_bits),  32'd12);
        check("t1_sat",   32'(if_def.out_sat),   32'd0);
        @(negedge clk);
        check("t1_drained", 32'(if_def.out_valid), 32'd0);

        // extremes: K0 25+23+25+23, K1 24+22+24+22, 6-bit total clips
        exp_q.push_back(16'd96);
        send_beat(pack4(-2048, 2047, -2048, 2047), 4'b1111, 1'b1);
        @(negedge clk);
        check("t2_bits",    32'(if_def.out_bits), 32'd96);
        check("t2_k1_bits", 32'(if_k1.out_bits),  32'd92);
        check("t2_s6_bits", 32'(if_s6.out_bits),  32'd63);
        check("t2_s6_sat",  32'(if_s6.out_sat),   32'd1);
        @(negedge clk);

        // K=1 with partial mask: ch0=-1 (4), ch1=0 (2); K=0 gives 3+1
        exp_q.push_back(16'd4);
        send_beat(pack4(0, -1, 0, -1), 4'b0011, 1'b1);
        @(negedge clk);
        check("t3_k1_bits", 32'(if_k1.out_bits),  32'd6);
        check("t3_bits",    32'(if_def.out_bits), 32'd4);
        @(negedge clk);

        // saturation: three beats of 4x(-2048); K0 100/beat, K1 96/beat
        exp_q.push_back(16'd300);
        send_beat(pack4(-2048, -2048, -2048, -2048), 4'b1111, 1'b0);
        send_beat(pack4(-2048, -2048, -2048, -2048), 4'b1111, 1'b0);
        check("t4_mid_valid", 32'(if_def.out_valid), 32'd0);
        send_beat(pack4(-2048, -2048, -2048, -2048), 4'b1111, 1'b1);
        @(negedge clk);
        check("t4_s6_bits", 32'(if_s6.out_bits),  32'd63);
        check("t4_s6_sat",  32'(if_s6.out_sat),   32'd1);
        check("t4_bits",    32'(if_def.out_bits), 32'd300);
        check("t4_sat",     32'(if_def.out_sat),  32'd0);
        check("t4_k1_bits", 32'(if_k1.out_bits),  32'd288);
        exp_q.push_back(16'd4);
        send_beat(pack4(0, 0, 0, 0), 4'b1111, 1'b1);
        @(negedge clk);
        check("t4_next_bits", 32'(if_s6.out_bits), 32'd4);
        check("t4_next_sat",  32'(if_s6.out_sat),  32'd0);

        // all channels masked: beat contributes 0 yet still closes the packet
        exp_q.push_back(16'd0);
        send_beat(pack4(5, 5, 5, 5), 4'b0000, 1'b1);
        @(negedge clk);
        check("t5_valid", 32'(if_def.out_valid), 32'd1);
        check("t5_bits",  32'(if_def.out_bits),  32'd0);
        @(negedge clk);

        // backpressure: two single-beat packets behind a stalled consumer
        drv_out_ready = 1'b0;
        exp_q.push_back(16'd12);
        exp_q.push_back(16'd4);
        send_beat(pack4(1, 1, 1, 1), 4'b1111, 1'b1);
        send_beat(pack4(0, 0, 0, 0), 4'b1111, 1'b1);
        check("t6_valid",    32'(if_def.out_valid), 32'd1);
        check("t6_bits",     32'(if_def.out_bits),  32'd12);
        check("t6_in_ready", 32'(if_def.in_ready),  32'd0);
        repeat (3) @(negedge clk);
        check("t6_hold_bits",  32'(if_def.out_bits), 32'd12);
        check("t6_hold_ready", 32'(if_def.in_ready), 32'd0);
        drv_out_ready = 1'b1;
        @(negedge clk);
        check("t6_b2b_valid", 32'(if_def.out_valid), 32'd1);
        check("t6_b2b_bits",  32'(if_def.out_bits),  32'd4);
        @(negedge clk);
        check("t6_drained", 32'(if_def.out_valid), 32'd0);

        // reset mid-packet discards the partial 24
        send_beat(pack4(1, 1, 1, 1), 4'b1111, 1'b0);
        send_beat(pack4(1, 1, 1, 1), 4'b1111, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("t7_rst_valid", 32'(if_def.out_valid), 32'd0);
        check("t7_rst_bits",  32'(if_def.out_bits),  32'd0);
        check("t7_rst_ready", 32'(if_def.in_ready),  32'd1);
        rstn = 1'b1;
        @(negedge clk);
        exp_q.push_back(16'd4);
        send_beat(pack4(0, 0, 0, 0), 4'b1111, 1'b1);
        @(negedge clk);
        check("t7_valid", 32'(if_def.out_valid), 32'd1);
        check("t7_bits",  32'(if_def.out_bits),  32'd4);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
